// File: rtl/alu_issue_queue_if.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | alu_issue_queue_if : issue-side push bus and ALU-side head bus          |
// | Rev 1.0                                                                 |
// +------------------------------------------------------------------------+
interface alu_issue_queue_if #(
  parameter int PTR_W = 1
);
  logic             in_alu_select;
  logic [5:0]       in_wfid;
  logic [31:0]      in_instr_pc;
  logic [31:0]      in_opcode;
  logic [15:0]      in_imm_value0;
  logic [31:0]      in_imm_value1;
  logic [11:0]      in_dest1_addr;
  logic [11:0]      in_dest2_addr;
  logic             in_alu_accept;
  logic             in_flush;
  logic             out_alu_ready;
  logic             out_valid;
  logic [5:0]       out_wfid;
  logic [31:0]      out_instr_pc;
  logic [31:0]      out_opcode;
  logic [15:0]      out_imm_value0;
  logic [31:0]      out_imm_value1;
  logic [11:0]      out_dest1_addr;
  logic [11:0]      out_dest2_addr;
  logic [PTR_W:0]   out_occupancy;
  logic             out_overflow;

  modport master (
    output in_alu_select, in_wfid, in_instr_pc, in_opcode, in_imm_value0,
           in_imm_value1, in_dest1_addr, in_dest2_addr, in_alu_accept, in_flush,
    input  out_alu_ready, out_valid, out_wfid, out_instr_pc, out_opcode,
           out_imm_value0, out_imm_value1, out_dest1_addr, out_dest2_addr,
           out_occupancy, out_overflow
  );

  modport slave (
    input  in_alu_select, in_wfid, in_instr_pc, in_opcode, in_imm_value0,
           in_imm_value1, in_dest1_addr, in_dest2_addr, in_alu_accept, in_flush,
    output out_alu_ready, out_valid, out_wfid, out_instr_pc, out_opcode,
           out_imm_value0, out_imm_value1, out_dest1_addr, out_dest2_addr,
           out_occupancy, out_overflow
  );
endinterface
`default_nettype wire

// File: rtl/alu_issue_queue.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | alu_issue_queue : in-order holding queue between issue and ALU front end|
// | Rev 1.0                                                                 |
// +------------------------------------------------------------------------+
module alu_issue_queue #(
  parameter int DEPTH = 2,
  parameter int PTR_W = 1
) (
  input  logic                clk,
  input  logic                rst,
  alu_issue_queue_if.slave    bus
);

  localparam int              ENTRY_W    = 142;
  localparam logic [PTR_W:0]  FULL_COUNT = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]  CNT_ONE    = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W:0]     count;
  logic               overflow;

  logic               full;
  logic               empty;
  logic               push;
  logic               pop;
  logic               push_refused;
  logic [ENTRY_W-1:0] wr_entry;
  logic [ENTRY_W-1:0] head_entry;

  // Ready depends on registered count only, so accept never reaches it.
  assign full         = (count == FULL_COUNT);
  assign empty        = (count == '0);
  assign push         = bus.in_alu_select & ~full & ~bus.in_flush;
  assign pop          = bus.in_alu_accept & ~empty & ~bus.in_flush;
  assign push_refused = bus.in_alu_select & full & ~bus.in_flush;

  assign wr_entry = {bus.in_wfid, bus.in_instr_pc, bus.in_opcode,
                     bus.in_imm_value0, bus.in_imm_value1,
                     bus.in_dest1_addr, bus.in_dest2_addr};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (bus.in_flush) begin
      rd_ptr <= wr_ptr;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      if (push && !pop) begin
        count <= count + CNT_ONE;
      end else if (pop && !push) begin
        count <= count - CNT_ONE;
      end
      if (push_refused) begin
        overflow <= 1'b1;
      end
    end
  end

  // Payload storage needs no reset: out_valid masks it until written.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_entry;
    end
  end

  assign head_entry = empty ? '0 : mem[rd_ptr];

  assign {bus.out_wfid, bus.out_instr_pc, bus.out_opcode,
          bus.out_imm_value0, bus.out_imm_value1,
          bus.out_dest1_addr, bus.out_dest2_addr} = head_entry;

  assign bus.out_alu_ready = ~full;
  assign bus.out_valid     = ~empty;
  assign bus.out_occupancy = count;
  assign bus.out_overflow  = overflow;

endmodule
`default_nettype wire

// File: doc/alu_issue_queue.md
Name: alu_issue_queue

Overview:
- Small in-order instruction queue directly downstream of the issue-to-ALU pipeline flops.
- Captures each ALU-selected instruction packet (wfid, PC, opcode, immediates, destinations) and holds it until the ALU execution front end accepts it.
- Exports a registered-state ready signal back toward issue so that instructions are not lost while the ALU stalls.
- Provides a global flush and a sticky overflow flag for debug and verification.

Parameters:
- DEPTH, 2, number of queue entries; power of two, at least 2.
- PTR_W, 1, pointer width; equals log2(DEPTH).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_alu_select  input  1  push request; one valid instruction packet this cycle.
- in_wfid  input  6  wavefront id.
- in_instr_pc  input  32  instruction PC.
- in_opcode  input  32  decoded opcode.
- in_imm_value0  input  16  immediate 0.
- in_imm_value1  input  32  immediate 1 / literal.
- in_dest1_addr  input  12  destination 1 address.
- in_dest2_addr  input  12  destination 2 address.
- in_alu_accept  input  1  ALU consumes the head entry this cycle.
- in_flush  input  1  discard all queued entries.
- out_alu_ready  output  1  queue can accept a push this cycle.
- out_valid  output  1  head entry present.
- out_wfid  output  6  head packet field.
- out_instr_pc  output  32  head packet field.
- out_opcode  output  32  head packet field.
- out_imm_value0  output  16  head packet field.
- out_imm_value1  output  32  head packet field.
- out_dest1_addr  output  12  head packet field.
- out_dest2_addr  output  12  head packet field.
- out_occupancy  output  PTR_W+1  number of valid entries.
- out_overflow  output  1  sticky; a push arrived while the queue was full.

Behaviour:
- Storage: DEPTH entries of 142 bits (6+32+32+16+32+12+12). Uses a write pointer, a read pointer and a count register, each PTR_W/PTR_W/PTR_W+1 bits. Pointers wrap modulo DEPTH.
- Reset (asynchronous, rst=1): count=0, pointers=0, out_overflow=0.
  - Resulting outputs: out_valid=0, out_alu_ready=1, out_occupancy=0, all packet outputs 0.
  - Entry storage contents are don't-care.
  - Reset asserted mid-operation drops all entries immediately.
- out_alu_ready = (count != DEPTH). It is decoded from registered state only, with no combinational path from in_alu_accept.
- out_valid = (count != 0).
- Packet outputs show the entry at the read pointer when out_valid=1, and are forced to 0 when empty.
- push = in_alu_select & out_alu_ready & ~in_flush. Writes the entry at the write pointer, then increments the write pointer.
- pop = in_alu_accept & out_valid & ~in_flush. Increments the read pointer.
- Count update: +1 on push only, -1 on pop only, unchanged when push and pop occur together.
  - Simultaneous push and pop is legal at any occupancy below DEPTH.
  - At count=DEPTH a push is refused even if a pop occurs in the same cycle.
- Latency: a packet pushed at edge N appears on the outputs with out_valid=1 after edge N, giving zero bubble.
- in_alu_accept while empty is ignored; no state change.
- Full-push error: in_alu_select=1 with count=DEPTH and in_flush=0 sets out_overflow=1.
  - The packet is dropped and queue state is unchanged.
  - out_overflow stays set until rst.
- Flush: in_flush=1 at an edge sets count=0 and read pointer = write pointer.
  - Any push or pop in the same cycle is discarded.
  - Flush does not set overflow.
  - Flush has priority over all other events.
- Ordering is strictly FIFO; there is no reordering by wfid.

Test Plan:
- Reset then idle: assert rst asynchronously between edges -> outputs clear immediately; out_alu_ready=1, out_valid=0, out_occupancy=0, all fields 0.
- Single pass-through: push wfid=6'h05, pc=32'h0000_0100, opcode=32'h1234_5678, with in_alu_accept=1 held -> out_valid=1 for exactly one cycle after the push edge showing those values, then empty; occupancy 0->1->0.
- Fill and stall (DEPTH=2): push pc=0x10, 0x14 with accept=0 -> occupancy=2, out_alu_ready=0, head pc=0x10. A third push pc=0x18 -> out_overflow=1 and occupancy stays 2. Then accept twice -> pc 0x10, then 0x14; pc 0x18 is never seen.
- Simultaneous push/pop with occupancy 1: push pc=0x20 while accepting head pc=0x1C -> occupancy stays 1, head becomes 0x20. Pointers wrap across 8 consecutive such cycles with no data corruption.
- Flush collision: occupancy 2, assert in_flush together with in_alu_select (pc=0x40) and in_alu_accept -> next cycle occupancy=0, out_valid=0, out_overflow unchanged. The next push pc=0x44 appears as head.
- Reset mid-operation: occupancy 2 with out_overflow=1, pulse rst -> all state cleared; a subsequent push of wfid=6'h3F is delivered normally.
